muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/alu_pkg.sv | 39 +++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants and multiply/divide op encodings
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } muldiv_op_t;

    localparam int MD_ITERATIONS = 32;

    // MUL is sign-agnostic in its low half, so it runs as unsigned.
    function automatic logic md_signed_a(input muldiv_op_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_signed_b(input muldiv_op_t op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi, lo[XLEN-1]};
        ge      = shifted >= {1'b0, operand};
        // The restored remainder is always below the divisor, so XLEN bits suffice.
        diff    = shifted[XLEN-1:0] - operand;
        if (is_div) begin
            hi_next = ge ? diff : shifted[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], ge};
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with valid/ready handshakes
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [2:0]      mdop,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] md_result,
    output logic            zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(MD_ITERATIONS);

    state_t          state, state_next;
    muldiv_op_t      op, op_in;
    logic [5:0]      cnt;
    logic [XLEN-1:0] acc_hi, acc_lo, opb;
    logic [XLEN-1:0] step_hi, step_lo;
    logic            neg_a, neg_b, div_zero;
    logic            sign_a_in, sign_b_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in;
    logic            iter_done;
    logic            accept;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, result_next;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign zero       = (md_result == '0);
    assign iter_done  = (cnt == CNT_LAST);
    assign accept     = req_valid && req_ready;

    always_comb begin
        op_in     = muldiv_op_t'(mdop);
        sign_a_in = md_signed_a(op_in) && data1[XLEN-1];
        sign_b_in = md_signed_b(op_in) && data2[XLEN-1];
        mag_a_in  = sign_a_in ? -data1 : data1;
        mag_b_in  = sign_b_in ? -data2 : data2;
    end

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op[2]),
        .hi      (acc_hi),
        .lo      (acc_lo),
        .operand (opb),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // Divide-by-zero only needs a quotient override: the remainder path
    // already yields the dividend magnitude, which the sign fixup restores.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = (neg_a ^ neg_b) ? -prod : prod;
        quo_fix  = div_zero ? '1 : ((neg_a ^ neg_b) ? -acc_lo : acc_lo);
        rem_fix  = neg_a ? -acc_hi : acc_hi;
        case (op)
            MD_MUL:                        result_next = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  result_next = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               result_next = quo_fix;
            default:                       result_next = rem_fix;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid)  state_next = CALC;
            CALC:    if (iter_done)  state_next = DONE;
            DONE:    if (resp_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= MD_MUL;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            div_zero  <= 1'b0;
            md_result <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op       <= op_in;
                        cnt      <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= mag_a_in;
                        opb      <= mag_b_in;
                        neg_a    <= sign_a_in;
                        neg_b    <= sign_b_in;
                        div_zero <= (data2 == '0);
                    end
                end
                CALC: begin
                    // One extra CALC cycle after the last iteration registers the fixed-up result.
                    if (!iter_done) begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + 6'd1;
                    end else begin
                        md_result <= result_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
